regfl_rd_seq: RTL and testbench

//  Read-side companion to the 8x64 register file (regfl). Snapshots the flat 512-bit

---
 rtl/regfl_rd_seq_if.sv | 29 ++
 rtl/regfl_rd_seq.sv | 128 ++++++++++++
 tb/tb_regfl_rd_seq.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/regfl_rd_seq_if.sv
// Output stream of the register-file read sequencer: one register word per beat.
interface regfl_rd_seq_if #(
  parameter int unsigned W  = 64,
  parameter int unsigned AW = 3
);
  logic [W-1:0]  dout;
  logic [AW-1:0] dout_idx;
  logic          vld;
  logic          rdy;
  logic          last;

  // Producer side: drives the beat, observes back-pressure
  modport master (
    output dout,
    output dout_idx,
    output vld,
    output last,
    input  rdy
  );

  // Consumer side
  modport slave (
    input  dout,
    input  dout_idx,
    input  vld,
    input  last,
    output rdy
  );
endinterface

// File: rtl/regfl_rd_seq.sv
// Read sequencer for the 8x64 register file: snapshots regfl.q on start and
// streams a burst of registers (with wrap) over a valid/ready handshake.
module regfl_rd_seq #(
  parameter int unsigned W  = 64,
  parameter int unsigned N  = 8,
  parameter int unsigned AW = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AW-1:0]        base,
  input  logic [AW:0]          cnt,
  input  logic [N*W-1:0]       q_in,
  regfl_rd_seq_if.master       m,
  output logic                 busy,
  output logic                 done
);

  localparam logic [AW:0] N_CNT = (AW+1)'(N);
  localparam logic [AW:0] ONE   = (AW+1)'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   snap_q [N];
  logic [W-1:0]   q_words [N];
  logic [AW-1:0]  ptr_q, ptr_d;
  logic [AW:0]    rem_q, rem_d;
  logic           snap_we;

  logic [W-1:0]   dout_q, dout_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic           vld_q, vld_d;
  logic           last_q, last_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  // Unpack the flat bus: register 0 sits in the most significant word
  for (genvar k = 0; k < int'(N); k++) begin : g_unpack
    assign q_words[k] = q_in[N*W-1-W*k -: W];
  end

  // Next-state and next-output logic; outputs are registered from these values
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    snap_we = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (cnt != '0) begin
            snap_we = 1'b1;
            ptr_d   = base;
            rem_d   = (cnt > N_CNT) ? N_CNT : cnt;
            state_d = SEND;
          end else begin
            state_d = DONE;
          end
        end
      end
      SEND: begin
        if (m.rdy) begin
          ptr_d = ptr_q + AW'(1);
          rem_d = rem_q - ONE;
          if (rem_q == ONE) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // First beat reads straight from the bus being snapshotted this edge
    dout_d = snap_we ? q_words[ptr_d] : snap_q[ptr_d];
    idx_d  = ptr_d;
    vld_d  = (state_d == SEND);
    last_d = (state_d == SEND) && (rem_d == ONE);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State, pointer and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      dout_q  <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      dout_q  <= dout_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Snapshot storage: captured once per burst so later regfl writes are invisible
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(N); k++) snap_q[k] <= '0;
    end else if (snap_we) begin
      for (int k = 0; k < int'(N); k++) snap_q[k] <= q_words[k];
    end
  end

  assign m.dout     = dout_q;
  assign m.dout_idx = idx_q;
  assign m.vld      = vld_q;
  assign m.last     = last_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_regfl_rd_seq.sv
// Directed bench for regfl_rd_seq: per-cycle vector table plus hand sequences.
module tb_regfl_rd_seq;

  localparam int unsigned W  = 64;
  localparam int unsigned N  = 8;
  localparam int unsigned AW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [AW-1:0]   base;
  logic [AW:0]     cnt;
  logic [N*W-1:0]  q_in;
  logic            busy;
  logic            done;
  logic [W-1:0]    regs [N];

  int total = 0;
  int bad   = 0;

  regfl_rd_seq_if #(.W(W), .AW(AW)) bus ();

  regfl_rd_seq #(.W(W), .N(N), .AW(AW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .base  (base),
    .cnt   (cnt),
    .q_in  (q_in),
    .m     (bus),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // Register-file model output
  always_comb begin
    q_in = '0;
    for (int k = 0; k < int'(N); k++) q_in[N*W-1-W*k -: W] = regs[k];
  end

  typedef struct {
    logic          start;
    logic [AW-1:0] base;
    logic [AW:0]   cnt;
    logic          rdy;
    logic          vld;
    logic [AW-1:0] idx;
    logic          last;
    logic          busy;
    logic          done;
  } vec_t;

  vec_t vq[$];

  function automatic logic [W-1:0] pat(input logic [AW-1:0] k);
    return {32'h1111_0000, 32'(k)};
  endfunction

  function automatic vec_t mk(input logic st, input int b, input int c, input logic r,
                              input logic v, input int i, input logic l,
                              input logic bs, input logic d);
    vec_t x;
    x.start = st; x.base = AW'(b); x.cnt = (AW+1)'(c); x.rdy = r;
    x.vld = v; x.idx = AW'(i); x.last = l; x.busy = bs; x.done = d;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Compare all status outputs; beat fields only while vld is expected
  task automatic chk_out(input string tag, input logic v, input logic [AW-1:0] i,
                         input logic [W-1:0] d, input logic l, input logic bs,
                         input logic dn);
    chk({tag, ".vld"},  W'(bus.vld), W'(v));
    chk({tag, ".last"}, W'(bus.last), W'(l));
    chk({tag, ".busy"}, W'(busy), W'(bs));
    chk({tag, ".done"}, W'(done), W'(dn));
    if (v) begin
      chk({tag, ".idx"},  W'(bus.dout_idx), W'(i));
      chk({tag, ".dout"}, bus.dout, d);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < int'(N); k++) regs[k] = pat(AW'(k));
    rst = 1'b1; start = 1'b1; base = '0; cnt = 4'd3; bus.rdy = 1'b1;

    // Reset held two cycles with start asserted: nothing starts
    for (int c = 0; c < 2; c++) begin
      tick();
      chk_out($sformatf("rst%0d", c), 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b0; start = 1'b0;
    tick();
    chk_out("post_rst", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    // base=2 cnt=3
    vq.push_back(mk(1, 2, 3, 1, 1, 2, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 1, 1, 3, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 1, 1, 4, 1, 1, 0));
    vq.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 1));
    vq.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
    // base=6 cnt=4 wraps
    vq.push_back(mk(1, 6, 4, 1, 1, 6, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 1, 1, 7, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 1, 1, 0, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 1, 1, 1, 1, 1, 0));
    vq.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 1));
    vq.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
    // base=5 cnt=15 clamps to 8 beats
    vq.push_back(mk(1, 5, 15, 1, 1, 5, 0, 1, 0));
    for (int k = 1; k < 8; k++)
      vq.push_back(mk(0, 0, 0, 1, 1, (5 + k) % 8, (k == 7), 1, 0));
    vq.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 1));
    vq.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
    // base=0 cnt=2 with rdy pattern 0,0,1,0,1
    vq.push_back(mk(1, 0, 2, 0, 1, 0, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 1, 1, 1, 1, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 1, 1, 1, 0));
    vq.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 1));
    vq.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));

    // Rows are applied before an edge; expectations are sampled after it
    for (int r = 0; r < vq.size(); r++) begin
      start   = vq[r].start;
      base    = vq[r].base;
      cnt     = vq[r].cnt;
      bus.rdy = vq[r].rdy;
      tick();
      chk_out($sformatf("row%0d", r), vq[r].vld, vq[r].idx, pat(vq[r].idx),
              vq[r].last, vq[r].busy, vq[r].done);
    end

    // Snapshot coherency: reg 3 rewritten mid-burst, starts during SEND ignored
    start = 1'b1; base = 3'd0; cnt = 4'd8; bus.rdy = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk_out($sformatf("coh%0d", k), 1'b1, AW'(k), pat(AW'(k)), (k == 7), 1'b1, 1'b0);
      if (k == 1) regs[3] = 64'hDEAD_BEEF_0000_0003;
      start = (k >= 2 && k <= 4);
      base  = 3'd5;
      cnt   = 4'd1;
      tick();
    end
    chk_out("coh_done", 1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_out("coh_idle", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("coh_idle2", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    // A fresh burst does see the new value of reg 3
    start = 1'b1; base = 3'd3; cnt = 4'd1;
    tick();
    start = 1'b0;
    chk_out("new3", 1'b1, 3'd3, 64'hDEAD_BEEF_0000_0003, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("new3_done", 1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    tick();
    regs[3] = pat(3'd3);

    // cnt=0: no beats, done next cycle
    start = 1'b1; base = 3'd4; cnt = 4'd0;
    tick();
    start = 1'b0;
    chk_out("zero_done", 1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    tick();
    chk_out("zero_idle", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    // Reset during beat 2 of a cnt=5 burst abandons it without done
    start = 1'b1; base = 3'd0; cnt = 4'd5;
    tick();
    start = 1'b0;
    chk_out("ab_b1", 1'b1, 3'd0, pat(3'd0), 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("ab_b2", 1'b1, 3'd1, pat(3'd1), 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_out("ab_rst", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("ab_nodone", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    // Next burst behaves as from reset
    start = 1'b1; base = 3'd1; cnt = 4'd2;
    tick();
    start = 1'b0;
    chk_out("rs_b1", 1'b1, 3'd1, pat(3'd1), 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("rs_b2", 1'b1, 3'd2, pat(3'd2), 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("rs_done", 1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    tick();
    chk_out("rs_idle", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
